// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands.

module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module seq_restoring_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] Data_in_Dividend,
   input  logic [WIDTH-1:0] Data_in_Divisor,
   output logic             Data_out_Ready,
   output logic             Data_out_Valid,
   output logic [WIDTH-1:0] Data_out_Quotient,
   output logic [WIDTH-1:0] Data_out_Remainder,
   output logic             Data_out_Div_By_Zero
);
   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] ITER_INIT = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_ZDIV,
      S_DONE
   } state_t;

   state_t state_q, state_d;
   logic [IW-1:0]    iter_q, iter_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] qo_q, qo_d;
   logic [WIDTH-1:0] ro_q, ro_d;
   logic             dbz_q, dbz_d;

   logic             accept;
   logic [WIDTH-1:0] dvd_in, dvs_in;
   logic [WIDTH-1:0] quo_next, rem_next;
   logic [WIDTH-1:0] quo_fix, rem_fix, zrem;
   logic [WIDTH:0]   p_sh, b_inv, diff, rem_full;
   logic [WIDTH+1:0] carry;
   logic             qbit;
   logic             unused_msb;

   assign Data_out_Ready = (state_q == S_IDLE) || (state_q == S_DONE);
   assign Data_out_Valid = (state_q == S_DONE);
   assign Data_out_Quotient = qo_q;
   assign Data_out_Remainder = ro_q;
   assign Data_out_Div_By_Zero = dbz_q;
   assign accept = start && Data_out_Ready;

   // Trial subtract: P' + ~{0,divisor} + 1, carry-out means no borrow
   assign p_sh = {rem_q, dvd_q[WIDTH-1]};
   assign b_inv = ~{1'b0, dvs_q};
   assign carry[0] = 1'b1;

   for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
      full_adder u_fa (
         .a_i (p_sh[i]),
         .b_i (b_inv[i]),
         .c_i (carry[i]),
         .s_o (diff[i]),
         .c_o (carry[i+1])
      );
   end

   assign qbit = carry[WIDTH+1];
   assign rem_full = qbit ? diff : p_sh;
   assign rem_next = rem_full[WIDTH-1:0];
   assign unused_msb = rem_full[WIDTH];
   assign quo_next = {quo_q[WIDTH-2:0], qbit};

`ifdef DIVIDER_SIGNED_EN
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   logic dneg_q, dneg_d;
   logic qneg_q, qneg_d;
   logic dvd_neg, dvs_neg;

   assign dvd_neg = Data_in_Dividend[WIDTH-1];
   assign dvs_neg = Data_in_Divisor[WIDTH-1];
   assign dvd_in = dvd_neg ? ~Data_in_Dividend + ONE : Data_in_Dividend;
   assign dvs_in = dvs_neg ? ~Data_in_Divisor + ONE : Data_in_Divisor;
   assign quo_fix = qneg_q ? ~quo_next + ONE : quo_next;
   assign rem_fix = dneg_q ? ~rem_next + ONE : rem_next;
   // Negating the stored magnitude recovers the original dividend
   assign zrem = dneg_q ? ~dvd_q + ONE : dvd_q;

   always_comb begin
      dneg_d = dneg_q;
      qneg_d = qneg_q;
      if (accept) begin
         dneg_d = dvd_neg;
         qneg_d = dvd_neg ^ dvs_neg;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         dneg_q <= 1'b0;
         qneg_q <= 1'b0;
      end else begin
         dneg_q <= dneg_d;
         qneg_q <= qneg_d;
      end
   end
`else
   assign dvd_in = Data_in_Dividend;
   assign dvs_in = Data_in_Divisor;
   assign quo_fix = quo_next;
   assign rem_fix = rem_next;
   assign zrem = dvd_q;
`endif

   always_comb begin
      state_d = state_q;
      iter_d = iter_q;
      dvd_d = dvd_q;
      dvs_d = dvs_q;
      rem_d = rem_q;
      quo_d = quo_q;
      qo_d = qo_q;
      ro_d = ro_q;
      dbz_d = dbz_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               dvd_d = dvd_in;
               dvs_d = dvs_in;
               rem_d = '0;
               quo_d = '0;
               iter_d = ITER_INIT;
               state_d = (Data_in_Divisor == '0) ? S_ZDIV : S_RUN;
            end
         end
         S_RUN: begin
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            rem_d = rem_next;
            quo_d = quo_next;
            if (iter_q == '0) begin
               qo_d = quo_fix;
               ro_d = rem_fix;
               dbz_d = 1'b0;
               state_d = S_DONE;
            end else begin
               iter_d = iter_q - 1'b1;
            end
         end
         S_ZDIV: begin
            qo_d = '1;
            ro_d = zrem;
            dbz_d = 1'b1;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         iter_q <= '0;
         dvd_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         qo_q <= '0;
         ro_q <= '0;
         dbz_q <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q <= iter_d;
         dvd_q <= dvd_d;
         dvs_q <= dvs_d;
         rem_q <= rem_d;
         quo_q <= quo_d;
         qo_q <= qo_d;
         ro_q <= ro_d;
         dbz_q <= dbz_d;
      end
   end
endmodule
